evt_doorbell_sched: RTL and testbench

//  - Captures single-cycle event pulses into per-event pending flags and serialises them to the SRIO doorbell TX port.
//  - Round-robin pick among pending events; one doorbell in flight at a time; matching response clears the event.
//  - Sits between the event sources and the SRIO iotx/iorx user ports; gated by link_initialized.

---
 rtl/evt_db_pkg.sv | 22 ++
 rtl/evt_rr_pick.sv | 39 +++
 rtl/evt_doorbell_sched.sv | 176 +++++++++++++++++
 tb/tb_evt_doorbell_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_db_pkg.sv
// Shared types and helpers for the doorbell event scheduler.
// Holds the FSM encoding, the default doorbell info base and an index-width helper.
package evt_db_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StSend,
    StWait
  } db_state_e;

  localparam logic [15:0] InfoBaseDefault = 16'hE000;

  // Minimum bit width able to hold values 0..n-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/evt_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requesting index at or after ptr, wrapping to 0.
module evt_rr_pick
  import evt_db_pkg::*;
#(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [clog2(N)-1:0]   idx,
  output logic                  any
);

  localparam int unsigned IW = clog2(N);

  logic [IW-1:0] idx_hi, idx_lo;
  logic          any_hi, any_lo;

  // Descending scans so the lowest qualifying index is the last one written.
  always_comb begin
    idx_hi = '0;
    idx_lo = '0;
    any_hi = 1'b0;
    any_lo = 1'b0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (req[j]) begin
        any_lo = 1'b1;
        idx_lo = IW'(j);
        if (IW'(j) >= ptr) begin
          any_hi = 1'b1;
          idx_hi = IW'(j);
        end
      end
    end
    idx = any_hi ? idx_hi : idx_lo;
    any = any_lo;
  end

endmodule

// File: rtl/evt_doorbell_sched.sv
// Event-to-SRIO-doorbell scheduler: pending flags, round-robin arbitration, one doorbell in flight.
// Define EVT_DB_RETRY_EN to resend up to MAX_RETRY times on timeout or ERROR response.
module evt_doorbell_sched
  import evt_db_pkg::*;
#(
  parameter int unsigned N_EVT     = 9,
  parameter int unsigned TID_W     = 8,
  parameter logic [15:0] INFO_BASE = InfoBaseDefault,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             link_initialized,
  input  logic [N_EVT-1:0] evt_in,
  output logic             iotx_tvalid,
  input  logic             iotx_tready,
  output logic [TID_W-1:0] iotx_tid,
  output logic [15:0]      iotx_info,
  input  logic             iorx_resp_valid,
  input  logic [TID_W-1:0] iorx_resp_tid,
  input  logic             iorx_resp_ok,
  output logic [N_EVT-1:0] evt_done,
  output logic [N_EVT-1:0] evt_err,
  output logic [N_EVT-1:0] evt_ovf,
  output logic             busy
);

  localparam int unsigned IW = clog2(N_EVT);
  localparam int unsigned CW = clog2(TIMEOUT);
  localparam int unsigned RW = clog2(MAX_RETRY + 1);

`ifdef EVT_DB_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  db_state_e        state_q, state_d;
  logic [N_EVT-1:0] pend_q, pend_d;
  logic [N_EVT-1:0] done_q, done_d;
  logic [N_EVT-1:0] err_q, err_d;
  logic [N_EVT-1:0] ovf_q, ovf_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TID_W-1:0] tid_q, tid_d;
  logic [TID_W-1:0] wait_tid_q, wait_tid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;

  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic          clr, fail, resp_hit;
  logic [IW-1:0] idx_next;

  evt_rr_pick #(
    .N (N_EVT)
  ) u_pick (
    .req (pend_q),
    .ptr (rr_q),
    .idx (grant_idx),
    .any (grant_any)
  );

  assign iotx_tvalid = (state_q == StSend) && link_initialized;
  assign iotx_tid    = tid_q;
  assign iotx_info   = (state_q == StSend) ? (INFO_BASE | 16'(idx_q)) : 16'h0;
  assign evt_done    = done_q;
  assign evt_err     = err_q;
  assign evt_ovf     = ovf_q;
  assign busy        = (state_q != StIdle);

  assign idx_next = (idx_q == IW'(N_EVT - 1)) ? '0 : idx_q + IW'(1);
  assign resp_hit = iorx_resp_valid && (iorx_resp_tid == wait_tid_q);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    idx_d      = idx_q;
    tid_d      = tid_q;
    wait_tid_d = wait_tid_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    done_d     = '0;
    err_d      = '0;
    clr        = 1'b0;
    fail       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (link_initialized && |pend_q) state_d = StArb;
      end
      StArb: begin
        if (!link_initialized || !grant_any) begin
          state_d = StIdle;
        end else begin
          idx_d   = grant_idx;
          retry_d = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (!link_initialized) begin
          state_d = StIdle;
        end else if (iotx_tready) begin
          wait_tid_d = tid_q;
          tid_d      = tid_q + TID_W'(1);
          cnt_d      = '0;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (!link_initialized) begin
          state_d = StIdle;
        end else if (resp_hit && iorx_resp_ok) begin
          clr           = 1'b1;
          done_d[idx_q] = 1'b1;
          rr_d          = idx_next;
          state_d       = StIdle;
        end else if (resp_hit || (cnt_q == CW'(TIMEOUT - 1))) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end

        if (fail) begin
          if (RetryEn && (retry_q < RW'(MAX_RETRY))) begin
            retry_d = retry_q + RW'(1);
            state_d = StSend;
          end else begin
            clr          = 1'b1;
            err_d[idx_q] = 1'b1;
            rr_d         = idx_next;
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // New pulses are applied after the clear so a same-cycle set survives.
    pend_d = pend_q;
    if (clr) pend_d[idx_q] = 1'b0;
    pend_d = pend_d | evt_in;
    ovf_d  = ovf_q | (evt_in & pend_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      done_q     <= '0;
      err_q      <= '0;
      ovf_q      <= '0;
      rr_q       <= '0;
      idx_q      <= '0;
      tid_q      <= '0;
      wait_tid_q <= '0;
      cnt_q      <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      rr_q       <= rr_d;
      idx_q      <= idx_d;
      tid_q      <= tid_d;
      wait_tid_q <= wait_tid_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
    end
  end

endmodule

// File: tb/tb_evt_doorbell_sched.sv
// Scoreboard bench for evt_doorbell_sched: stimulus pushes expected doorbells/pulses,
// a monitor pops and compares them as the DUT presents them.
module tb_evt_doorbell_sched;

  localparam int unsigned NEvt    = 9;
  localparam int unsigned Tmo     = 20;
  localparam int          KHs     = 0;
  localparam int          KDone   = 1;
  localparam int          KErr    = 2;
  localparam int          RspOk   = 0;
  localparam int          RspNone = 1;
  localparam int          RspErr  = 2;
  localparam int          RspBad  = 3;
`ifdef EVT_DB_RETRY_EN
  localparam int          Sends   = 4;
`else
  localparam int          Sends   = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            link_initialized = 1'b1;
  logic [NEvt-1:0] evt_in = '0;
  logic            iotx_tvalid;
  logic            iotx_tready = 1'b1;
  logic [7:0]      iotx_tid;
  logic [15:0]     iotx_info;
  logic            iorx_resp_valid;
  logic [7:0]      iorx_resp_tid;
  logic            iorx_resp_ok;
  logic [NEvt-1:0] evt_done, evt_err, evt_ovf;
  logic            busy;

  evt_doorbell_sched #(
    .N_EVT     (NEvt),
    .TID_W     (8),
    .INFO_BASE (16'hE000),
    .TIMEOUT   (Tmo),
    .MAX_RETRY (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .link_initialized (link_initialized),
    .evt_in           (evt_in),
    .iotx_tvalid      (iotx_tvalid),
    .iotx_tready      (iotx_tready),
    .iotx_tid         (iotx_tid),
    .iotx_info        (iotx_info),
    .iorx_resp_valid  (iorx_resp_valid),
    .iorx_resp_tid    (iorx_resp_tid),
    .iorx_resp_ok     (iorx_resp_ok),
    .evt_done         (evt_done),
    .evt_err          (evt_err),
    .evt_ovf          (evt_ovf),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int tid;
    int val;
    int at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rsp_mode = RspOk;
  int   rsp_delay = 0;
  logic [7:0] rsp_tid = '0;
  logic       rsp_ok_v = 1'b0;
  logic       rsp_bad = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int tid, input int val, input int at);
    exp_t e;
    e.kind = kind;
    e.tid  = tid;
    e.val  = val;
    e.at   = at;
    sb.push_back(e);
  endfunction

  task automatic pop_cmp(input int kind, input int tid, input int val);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_output_kind", kind, 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("out_kind", kind, e.kind);
      if (e.kind == KHs) chk("hs_tid", tid, e.tid);
      chk(kind == KHs ? "hs_info" : "pulse_mask", val, e.val);
      if (e.at >= 0) chk("out_cycle", cyc, e.at);
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (iotx_tvalid && iotx_tready) pop_cmp(KHs, int'(iotx_tid), int'(iotx_info));
      if (|evt_done) pop_cmp(KDone, 0, int'(evt_done));
      if (|evt_err) pop_cmp(KErr, 0, int'(evt_err));
    end
  end

  // Remote endpoint: answers each accepted doorbell two cycles later.
  initial begin
    iorx_resp_valid = 1'b0;
    iorx_resp_tid   = '0;
    iorx_resp_ok    = 1'b0;
    forever begin
      @(negedge clk);
      iorx_resp_valid = 1'b0;
      if (rsp_delay > 0) begin
        rsp_delay--;
        if (rsp_delay == 0) begin
          iorx_resp_valid = 1'b1;
          iorx_resp_tid   = rsp_tid;
          iorx_resp_ok    = rsp_ok_v;
        end else if (rsp_delay == 2 && rsp_bad) begin
          iorx_resp_valid = 1'b1;
          iorx_resp_tid   = rsp_tid + 8'd5;
          iorx_resp_ok    = 1'b0;
        end
      end
      if (!rst && iotx_tvalid && iotx_tready && rsp_mode != RspNone) begin
        rsp_tid   = iotx_tid;
        rsp_ok_v  = (rsp_mode != RspErr);
        rsp_bad   = (rsp_mode == RspBad);
        rsp_delay = rsp_bad ? 4 : 2;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    evt_in = '0;
    iotx_tready = 1'b1;
    link_initialized = 1'b1;
    rsp_mode = RspOk;
    rsp_delay = 0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse(input logic [NEvt-1:0] m, output int p);
    @(posedge clk);
    #1 evt_in = m;
    p = cyc;
    @(posedge clk);
    #1 evt_in = '0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    chk(nm, sb.size(), 0);
    sb.delete();
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    do_reset();
    chk("rst_tvalid", iotx_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", evt_done, 0);
    chk("rst_err", evt_err, 0);
    chk("rst_ovf", evt_ovf, 0);
    chk("rst_tid", iotx_tid, 0);
    chk("rst_info", iotx_info, 0);

    // Single event, OK response.
    pulse(9'h001, p);
    push(KHs, 0, 16'hE000, p + 3);
    push(KDone, 0, 9'h001, -1);
    drain("single_drain", 100);
    chk("single_idle", busy, 0);

    // All nine together: index order, tids 0..8.
    do_reset();
    pulse(9'h1FF, p);
    for (int i = 0; i < 9; i++) begin
      push(KHs, i, 16'hE000 + i, (i == 0) ? p + 3 : -1);
      push(KDone, 0, 1 << i, -1);
    end
    drain("all9_drain", 400);

    // Coalesced pulses on event 2.
    do_reset();
    @(posedge clk);
    #1 evt_in = 9'h004;
    p = cyc;
    @(posedge clk);
    #1 evt_in = 9'h004;
    @(posedge clk);
    #1 evt_in = '0;
    push(KHs, 0, 16'hE002, p + 3);
    push(KDone, 0, 9'h004, -1);
    drain("coal_drain", 100);
    chk("coal_ovf", evt_ovf, 9'h004);
    do_reset();
    chk("coal_ovf_rst", evt_ovf, 0);

    // Timeout with no response.
    rsp_mode = RspNone;
    pulse(9'h002, p);
    for (int k = 0; k < Sends; k++) push(KHs, k, 16'hE001, p + 3 + k * (Tmo + 1));
    push(KErr, 0, 9'h002, p + 3 + Sends * (Tmo + 1));
    drain("tmo_drain", 6 * (Tmo + 1) + 40);

    // ERROR responses.
    do_reset();
    rsp_mode = RspErr;
    pulse(9'h010, p);
    for (int k = 0; k < Sends; k++) push(KHs, k, 16'hE004, -1);
    push(KErr, 0, 9'h010, -1);
    drain("errresp_drain", 100);

    // Link drop while waiting, then resend with a new tid.
    do_reset();
    rsp_mode = RspNone;
    pulse(9'h008, p);
    push(KHs, 0, 16'hE003, p + 3);
    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(posedge clk);
        #1 n++;
      end
      chk("link_hs_seen", sb.size(), 0);
    end
    chk("link_busy_wait", busy, 1);
    @(posedge clk);
    #1 link_initialized = 1'b0;
    @(posedge clk);
    #1;
    chk("link_busy_drop", busy, 0);
    chk("link_tvalid_drop", iotx_tvalid, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("link_busy_down", busy, 0);
    rsp_mode = RspOk;
    push(KHs, 1, 16'hE003, -1);
    push(KDone, 0, 9'h008, -1);
    link_initialized = 1'b1;
    drain("link_resend_drain", 100);

    // Back-pressure for 50 cycles, then a wrong-tid ERROR ahead of the real DONE.
    do_reset();
    iotx_tready = 1'b0;
    rsp_mode = RspBad;
    pulse(9'h020, p);
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 50; i++) begin
      chk("stall_tvalid", iotx_tvalid, 1);
      chk("stall_tid", iotx_tid, 0);
      chk("stall_info", iotx_info, 16'hE005);
      @(posedge clk);
      #1;
    end
    push(KHs, 0, 16'hE005, -1);
    push(KDone, 0, 9'h020, -1);
    iotx_tready = 1'b1;
    drain("stall_drain", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
